instr_sequencer: RTL
====================

# instr_sequencer

Top-level instruction sequencer for the microcontroller core. It fetches one instruction word per instruction from synchronous program memory, decodes the 3-bit opcode, and starts exactly one execution sub-FSM (MOVI, ADD, etc.) via a one-hot start/done handshake. It owns the program counter, honouring per-unit PC-increment requests for multi-word instructions. A watchdog traps execution units that never report done.

## Interface
- `PC_WIDTH`, 8: program counter width; PC wraps modulo 2^PC_WIDTH.
- `INSTR_WIDTH`, 16: instruction word width; opcode is bits [INSTR_WIDTH-1 -: 3].
- `TIMEOUT_CYCLES`, 15: maximum WAIT cycles before FAULT; legal range 1..255.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; sequencer leaves IDLE and continues fetching while high.
- `instr_data` in INSTR_WIDTH: program memory read data, valid one cycle after `pc` is presented.
- `pc` out PC_WIDTH: program memory address / current PC.
- `ir` out INSTR_WIDTH: latched instruction word, drives unit operand fields.
- `unit_start` out 7: one-hot, one-cycle start pulse; bit n = opcode n (0..6).
- `unit_done` in 7: done from each unit; only the active unit's bit is observed.
- `unit_pc_inc` in 7: PC-increment request from each unit; only the active unit's bit is observed.
- `busy` out 1: high in every state except IDLE, HALT and FAULT.
- `halted` out 1: sticky, set by HALT opcode (7).
- `fault` out 1: sticky, set by watchdog expiry.

## Operation
- States: IDLE, FETCH, DECODE, DISPATCH, WAIT, ADVANCE, HALT, FAULT.
- IDLE -> FETCH when `run`=1; otherwise hold.
- FETCH: `pc` stable -> DECODE.
- DECODE: `ir` <= `instr_data`. If opcode = 7, go to HALT; otherwise go to DISPATCH and record the active unit index.
- DISPATCH: `unit_start[op]` = 1 for this cycle only; watchdog cleared -> WAIT.
- WAIT: on each cycle with `unit_pc_inc[op]`=1, `pc` <= `pc`+1.
  - `unit_done[op]`=1 -> ADVANCE.
  - Otherwise the watchdog increments; on reaching TIMEOUT_CYCLES -> FAULT.
- ADVANCE: `pc` <= `pc`+1 (steps past the opcode word) -> FETCH if `run`=1, else IDLE.
- HALT, FAULT: absorbing; only `reset` exits. `pc` frozen; in HALT it points at the HALT word.
- `run` dropping mid-instruction: the current instruction completes, then the sequencer goes to IDLE. `run` is sampled only in IDLE and ADVANCE.
- Done and pc_inc from the active unit in the same cycle: both honoured. That cycle adds +1, and ADVANCE adds a further +1.
- `unit_done` during DISPATCH, and done/pc_inc from non-active units: ignored.
- PC arithmetic is unsigned, PC_WIDTH bits; 2^PC_WIDTH-1 + 1 = 0 with no flag.

## Timing
- Reset values: `pc`=0, `ir`=0, `unit_start`=0, `busy`=0, `halted`=0, `fault`=0, state=IDLE, watchdog=0.
- Reset mid-instruction: all outputs take reset values at the next edge; any in-flight unit is abandoned. Units share `reset`.
- Single-word instruction with done in the k-th WAIT cycle (k>=1): 4+k cycles from FETCH entry to the next FETCH.
- `unit_start` is registered: high exactly during DISPATCH.
- A unit whose done arrives on WAIT cycle TIMEOUT_CYCLES completes normally. The FAULT transition occurs when WAIT cycle TIMEOUT_CYCLES passes without done.
- `halted` rises on the cycle after DECODE of opcode 7. `fault` rises on the cycle after the expiring WAIT cycle.

## Structure
- Shared package `uc_pkg`: opcode localparams (OP_MOVI etc., OP_HALT=3'd7), state enum, NUM_UNITS=7.
- Sub-module `seq_watchdog`: clear/enable inputs, 8-bit counter, `expired` output compared against TIMEOUT_CYCLES.
- Everything else (FSM, PC, IR, start decode) stays flat in `instr_sequencer`.

## Test plan
- Reset then `run`=1; memory[0]=opcode 2, unit 2 done on first WAIT cycle -> `unit_start`=7'b0000100 for one cycle; `pc`=1 after ADVANCE; next FETCH 5 cycles after the first.
- MOVI (opcode 0) asserting pc_inc for one WAIT cycle, then done two cycles later -> `pc` goes 0->1->2; next fetch from address 2.
- Memory[5]=opcode 7 -> `halted`=1, `busy`=0, `pc` held at 5 indefinitely; no `unit_start` pulse.
- Unit 3 never asserts done, TIMEOUT_CYCLES=15 -> `fault`=1 after the 15th WAIT cycle; `pc` unchanged; a spurious `unit_done[4]` pulse during WAIT has no effect.
- `pc`=8'hFF with single-word instruction -> `pc`=8'h00 after ADVANCE.
- Assert `reset` during WAIT, and drop `run` during WAIT:
  - reset -> all outputs at reset values the next cycle.
  - `run` drop -> instruction completes, state IDLE, `busy`=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the microcontroller core: opcodes, sequencer states
// and the opcode-to-unit one-hot decode used by the instruction sequencer.
package uc_pkg;

  localparam int NUM_UNITS = 7;

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;
  localparam logic [2:0] OP_OUT  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_DISPATCH,
    ST_WAIT,
    ST_ADVANCE,
    ST_HALT,
    ST_FAULT
  } seq_state_t;

  // OP_HALT has no execution unit, so it maps to an all-zero mask.
  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [2:0] op);
    logic [NUM_UNITS-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (op == 3'(i)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Watchdog for the instruction sequencer: counts WAIT cycles without done and
// flags the cycle on which the count would reach TIMEOUT_CYCLES.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // Expiry is judged on the cycle being counted, so the FSM can leave WAIT
  // on the same edge that would have made the count equal TIMEOUT_CYCLES.
  assign expired = enable && (({1'b0, count} + 9'd1) == 9'(TIMEOUT_CYCLES));

endmodule

// File: rtl/instr_sequencer.sv
// Top-level instruction sequencer: fetches and decodes one instruction word,
// dispatches exactly one execution unit and owns the program counter.
module instr_sequencer
  import uc_pkg::*;
#(
  parameter int PC_WIDTH       = 8,
  parameter int INSTR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [INSTR_WIDTH-1:0] instr_data,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [NUM_UNITS-1:0]   unit_start,
  input  logic [NUM_UNITS-1:0]   unit_done,
  input  logic [NUM_UNITS-1:0]   unit_pc_inc,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  seq_state_t state, next_state;

  logic [NUM_UNITS-1:0] active_mask;
  logic [NUM_UNITS-1:0] decode_mask;
  logic [2:0]           opcode;
  logic                 active_done;
  logic                 active_pc_inc;
  logic                 wd_clear;
  logic                 wd_enable;
  logic                 wd_expired;

  assign opcode        = instr_data[INSTR_WIDTH-1 -: 3];
  assign decode_mask   = unit_onehot(opcode);
  assign active_done   = |(unit_done & active_mask);
  assign active_pc_inc = |(unit_pc_inc & active_mask);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    next_state = state;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    case (state)
      ST_IDLE:     if (run) next_state = ST_FETCH;
      ST_FETCH:    next_state = ST_DECODE;
      ST_DECODE:   next_state = (opcode == OP_HALT) ? ST_HALT : ST_DISPATCH;
      ST_DISPATCH: begin
        wd_clear   = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (active_done) begin
          next_state = ST_ADVANCE;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) next_state = ST_FAULT;
        end
      end
      ST_ADVANCE:  next_state = run ? ST_FETCH : ST_IDLE;
      ST_HALT:     next_state = ST_HALT;
      ST_FAULT:    next_state = ST_FAULT;
      default:     next_state = ST_IDLE;
    endcase
  end

  // unit_start is loaded on the DECODE->DISPATCH edge so it is high exactly
  // while the FSM sits in DISPATCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      ir          <= '0;
      unit_start  <= '0;
      active_mask <= '0;
    end else begin
      state      <= next_state;
      unit_start <= '0;
      case (state)
        ST_DECODE: begin
          ir <= instr_data;
          if (next_state == ST_DISPATCH) begin
            active_mask <= decode_mask;
            unit_start  <= decode_mask;
          end
        end
        ST_WAIT:    if (active_pc_inc) pc <= pc + PC_ONE;
        ST_ADVANCE: pc <= pc + PC_ONE;
        default:    ;
      endcase
    end
  end

  // HALT and FAULT are absorbing, so the state register already holds them sticky.
  assign busy   = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_FAULT);
  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

endmodule
